multicast_bus_driver: RTL and testbench
=======================================

// Module: multicast_bus_driver
// PURPOSE
// - Upstream feeder of one row/column multicast bus of MulticastController instances.
// - Configuration: shifts PE IDs into the controllers' ID scan chain (set_id/id_in).
// - Run: buffers (tag,value) packets in a FIFO and issues them on the bus with enable/ready flow control.
// PARAMETERS
// - ID_LEN      4   width of tag and scan-chain ID
// - VALUE_LEN   32  width of the data value
// - FIFO_DEPTH  4   packet FIFO entries; power of 2, >=2
// - CHAIN_LEN   8   number of controllers on the scan chain (shifts per config)
// PORTS
// - clk        in   1          single clock, all state on posedge
// - rst        in   1          synchronous, active-low reset
// - cfg_start  in   1          pulse in IDLE: begin ID configuration
// - cfg_valid  in   1          cfg_id valid
// - cfg_id     in   ID_LEN     next ID to shift (farthest controller first)
// - cfg_ready  out  1          driver accepts cfg_id this cycle
// - cfg_done   out  1          one-cycle pulse after last shift
// - flush      in   1          request return from RUN to IDLE once drained
// - pkt_valid  in   1          input packet valid
// - pkt_tag    in   ID_LEN     destination ID
// - pkt_value  in   VALUE_LEN  payload
// - pkt_ready  out  1          FIFO not full
// - set_id     out  1          scan-chain shift strobe to all controllers
// - id_out     out  ID_LEN     ID into first controller's id_in
// - bus_enable out  1          bus packet valid
// - bus_tag    out  ID_LEN     bus tag
// - bus_value  out  VALUE_LEN  bus value
// - bus_ready  in   1          aggregated ready from the controllers
// - busy       out  1          state != IDLE or FIFO/bus stage occupied
// BEHAVIOUR
// - Reset (rst==0 at posedge): state=IDLE, FIFO empty, bus stage empty; all outputs 0
//   except pkt_ready=1. Reset mid-config or mid-stream discards all packets and shift progress.
// - FSM: IDLE -cfg_start-> CONFIG -CHAIN_LEN shifts-> RUN -flush & drained-> IDLE.
//   cfg_start outside IDLE and flush outside RUN are ignored.
// - CONFIG: cfg_ready=1; each cfg_valid cycle registers id_out=cfg_id, set_id=1 next cycle
//   (one shift per accepted ID). Shift counter wraps at CHAIN_LEN: last shift -> cfg_done=1
//   in the same cycle as that set_id, state=RUN the cycle after. set_id=0 outside CONFIG.
// - FIFO: push when pkt_valid & pkt_ready; pkt_ready = !full (full blocks push even if a pop
//   occurs in the same cycle). Accepted in every state, including IDLE/CONFIG.
// - Bus stage: registered (bus_enable, bus_tag, bus_value). Transfer = bus_enable & bus_ready.
//   In RUN, stage loads from FIFO head when empty or transferring; simultaneous transfer and
//   load keeps bus_enable=1 (back-to-back, 1 packet/cycle). No FIFO bypass.
// - Min latency: packet accepted in cycle t (FIFO empty, RUN) -> bus_enable=1 in cycle t+2.
// - Stall: bus_enable=0 or bus_ready=0 holds tag/value stable; bus_value=0 when bus_enable=0.
// - Outside RUN, stage is not loaded; a packet already in stage still completes.
// - flush in RUN is sticky; leave for IDLE when FIFO empty and stage empty (or transferring
//   the last packet that cycle).
// - Pointers are log2(FIFO_DEPTH) bits, wrap naturally; count is log2(FIFO_DEPTH)+1 bits.
// CONFIGURATION
// - MCAST_PERF_CNT_EN defined: adds outputs perf_xfer[31:0] (transfers) and perf_stall[31:0]
//   (cycles with bus_enable & !bus_ready); saturating, cleared by reset and on cfg_start.
// - Not defined: those ports and counters are absent; behaviour otherwise identical.
// TESTING
// - Config CHAIN_LEN=8, cfg_id 7..0 -> 8 set_id pulses, id_out sequence 7..0, cfg_done with 8th, RUN next.
// - RUN, bus_ready=1, push tags 1,2,3 back-to-back -> bus_enable from t+2, tags 1,2,3 on consecutive cycles.
// - bus_ready=0, push 5 packets (depth 4) -> 1 in stage + 4 in FIFO, pkt_ready=0; release -> order kept.
// - Push 2 packets while in CONFIG -> bus_enable stays 0 until cycle after state becomes RUN.
// - Drive rst=0 mid-stream with 3 queued -> next cycle bus_enable=0, pkt_ready=1, busy=0, state IDLE.
// - flush with 2 queued, bus_ready=1 -> IDLE after last transfer; with PERF: perf_xfer=2, perf_stall=0.

Source files
------------

// File: rtl/multicast_bus_driver.sv
// Feeder for one multicast bus: configures the controllers' ID scan chain, then streams
// FIFO-buffered (tag,value) packets. Optional perf counters: define MCAST_PERF_CNT_EN.
module multicast_bus_driver #(
  parameter int ID_LEN     = 4,
  parameter int VALUE_LEN  = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CHAIN_LEN  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic                 cfg_valid,
  input  logic [ID_LEN-1:0]    cfg_id,
  output logic                 cfg_ready,
  output logic                 cfg_done,
  input  logic                 flush,
  input  logic                 pkt_valid,
  input  logic [ID_LEN-1:0]    pkt_tag,
  input  logic [VALUE_LEN-1:0] pkt_value,
  output logic                 pkt_ready,
  output logic                 set_id,
  output logic [ID_LEN-1:0]    id_out,
  output logic                 bus_enable,
  output logic [ID_LEN-1:0]    bus_tag,
  output logic [VALUE_LEN-1:0] bus_value,
  input  logic                 bus_ready,
`ifdef MCAST_PERF_CNT_EN
  output logic [31:0]          perf_xfer,
  output logic [31:0]          perf_stall,
`endif
  output logic                 busy
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int SCW = $clog2(CHAIN_LEN + 1);
  localparam int EW  = ID_LEN + VALUE_LEN;

  typedef enum logic [1:0] {S_IDLE, S_CONFIG, S_RUN} state_t;

  state_t               state_q, state_d;
  logic                 set_id_q, cfg_done_q, flush_q, flush_d;
  logic [SCW-1:0]       shift_cnt_q, shift_cnt_d;
  logic [ID_LEN-1:0]    id_out_q;
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q, count_d;
  logic [EW-1:0]        mem_q [FIFO_DEPTH];
  logic [EW-1:0]        head;
  logic                 bus_en_q;
  logic [ID_LEN-1:0]    bus_tag_q;
  logic [VALUE_LEN-1:0] bus_val_q;

  logic run, start_acc, cfg_acc, last_shift, full, empty, push, pop, xfer, load, drained, leave;

  assign run        = (state_q == S_RUN);
  assign start_acc  = (state_q == S_IDLE) && cfg_start;
  assign cfg_acc    = cfg_valid && cfg_ready;
  assign last_shift = (shift_cnt_q == SCW'(CHAIN_LEN - 1));
  assign full       = (count_q == CW'(FIFO_DEPTH));
  assign empty      = (count_q == '0);
  assign push       = pkt_valid && !full;
  assign xfer       = bus_en_q && bus_ready;
  assign load       = run && !empty && (!bus_en_q || bus_ready);
  assign pop        = load;
  // Drained also covers the last packet leaving the stage in this very cycle.
  assign drained    = empty && (!bus_en_q || bus_ready);
  assign leave      = run && (flush_q || flush) && drained;
  assign head       = mem_q[rd_ptr_q];

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (cfg_start)  state_d = S_CONFIG;
      S_CONFIG: if (cfg_done_q) state_d = S_RUN;
      S_RUN:    if (leave)      state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    cfg_ready = (state_q == S_CONFIG) && !cfg_done_q;
    pkt_ready = !full;
    busy      = (state_q != S_IDLE) || !empty || bus_en_q;
  end

  always_comb begin
    shift_cnt_d = shift_cnt_q;
    if (start_acc)    shift_cnt_d = '0;
    else if (cfg_acc) shift_cnt_d = last_shift ? '0 : shift_cnt_q + SCW'(1);
    flush_d = 1'b0;
    if (run && !leave) flush_d = flush_q || flush;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      set_id_q    <= 1'b0;
      cfg_done_q  <= 1'b0;
      shift_cnt_q <= '0;
      id_out_q    <= '0;
      flush_q     <= 1'b0;
    end else begin
      set_id_q    <= cfg_acc;
      cfg_done_q  <= cfg_acc && last_shift;
      shift_cnt_q <= shift_cnt_d;
      flush_q     <= flush_d;
      if (cfg_acc) id_out_q <= cfg_id;
    end
  end

  // Packet FIFO; a full FIFO refuses a push even when a pop happens the same cycle.
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {pkt_tag, pkt_value};
  end

  // Bus output stage
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus_en_q  <= 1'b0;
      bus_tag_q <= '0;
    end else if (load) begin
      bus_en_q  <= 1'b1;
      bus_tag_q <= head[EW-1:VALUE_LEN];
    end else if (xfer) begin
      bus_en_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load) bus_val_q <= head[VALUE_LEN-1:0];
  end

  assign set_id     = set_id_q;
  assign cfg_done   = cfg_done_q;
  assign id_out     = id_out_q;
  assign bus_enable = bus_en_q;
  assign bus_tag    = bus_tag_q;
  assign bus_value  = bus_en_q ? bus_val_q : '0;

`ifdef MCAST_PERF_CNT_EN
  logic [31:0] perf_xfer_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (!rst || start_acc) begin
      perf_xfer_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (xfer && (perf_xfer_q != '1))                     perf_xfer_q  <= perf_xfer_q + 32'd1;
      if (bus_en_q && !bus_ready && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_xfer  = perf_xfer_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_multicast_bus_driver.sv
// Randomized bench for multicast_bus_driver against a queue-based behavioural model.
module tb_multicast_bus_driver;
  localparam int IDL = 4, VL = 32, DEPTH = 4, CHAIN = 8;

  logic clk = 1'b0;
  logic rst, cfg_start, cfg_valid, flush, pkt_valid, bus_ready;
  logic [IDL-1:0] cfg_id, pkt_tag;
  logic [VL-1:0]  pkt_value;
  logic cfg_ready, cfg_done, pkt_ready, set_id, bus_enable, busy;
  logic [IDL-1:0] id_out, bus_tag;
  logic [VL-1:0]  bus_value;
`ifdef MCAST_PERF_CNT_EN
  logic [31:0] perf_xfer, perf_stall;
`endif

  multicast_bus_driver #(.ID_LEN(IDL), .VALUE_LEN(VL), .FIFO_DEPTH(DEPTH), .CHAIN_LEN(CHAIN)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_id(cfg_id),
    .cfg_ready(cfg_ready), .cfg_done(cfg_done), .flush(flush), .pkt_valid(pkt_valid),
    .pkt_tag(pkt_tag), .pkt_value(pkt_value), .pkt_ready(pkt_ready), .set_id(set_id),
    .id_out(id_out), .bus_enable(bus_enable), .bus_tag(bus_tag), .bus_value(bus_value),
    .bus_ready(bus_ready),
`ifdef MCAST_PERF_CNT_EN
    .perf_xfer(perf_xfer), .perf_stall(perf_stall),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [IDL-1:0] tag; logic [VL-1:0] val; } pkt_t;

  // Reference model: q holds every accepted, not yet transferred packet in order;
  // when on_bus is set, q[0] is the packet presented on the bus.
  pkt_t q[$];
  bit on_bus, m_done, m_setid, m_flush;
  int m_mode;  // 0 idle, 1 config, 2 run
  int m_shifts;
  logic [IDL-1:0] m_id;
  int m_px, m_ps;
  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int fifo_n;
    bit run, cfg_rdy, xfer, ld, leave, acc, done_new;
    if (!rst) begin
      q.delete(); on_bus = 0; m_done = 0; m_setid = 0; m_flush = 0;
      m_mode = 0; m_shifts = 0; m_id = '0; m_px = 0; m_ps = 0;
      return;
    end
    fifo_n  = q.size() - int'(on_bus);
    run     = (m_mode == 2);
    cfg_rdy = (m_mode == 1) && !m_done;
    xfer    = on_bus && bus_ready;
    ld      = run && fifo_n > 0 && (!on_bus || bus_ready);
    leave   = run && (m_flush || flush) && fifo_n == 0 && (!on_bus || bus_ready);
    acc     = cfg_valid && cfg_rdy;
    if (m_mode == 0 && cfg_start) begin
      m_px = 0; m_ps = 0;
    end else begin
      if (xfer) m_px++;
      if (on_bus && !bus_ready) m_ps++;
    end
    if (xfer) void'(q.pop_front());
    if (pkt_valid && fifo_n < DEPTH) q.push_back({pkt_tag, pkt_value});
    if (ld) on_bus = 1; else if (xfer) on_bus = 0;
    m_setid  = acc;
    done_new = 0;
    if (acc) begin
      m_id = cfg_id;
      m_shifts++;
      if (m_shifts == CHAIN) begin done_new = 1; m_shifts = 0; end
    end
    case (m_mode)
      0: if (cfg_start) begin m_mode = 1; m_shifts = 0; end
      1: if (m_done) m_mode = 2;
      default: if (leave) begin m_mode = 0; m_flush = 0; end
               else if (flush) m_flush = 1;
    endcase
    m_done = done_new;
  endtask

  task automatic check_all();
    chk("bus_enable", bus_enable, on_bus);
    if (on_bus) begin
      chk("bus_tag", bus_tag, q[0].tag);
      chk("bus_value", bus_value, q[0].val);
    end else begin
      chk("bus_value_idle", bus_value, 0);
    end
    chk("pkt_ready", pkt_ready, (q.size() - int'(on_bus)) < DEPTH);
    chk("busy", busy, (m_mode != 0) || (q.size() != 0));
    chk("cfg_ready", cfg_ready, (m_mode == 1) && !m_done);
    chk("set_id", set_id, m_setid);
    chk("id_out", id_out, m_id);
    chk("cfg_done", cfg_done, m_done);
`ifdef MCAST_PERF_CNT_EN
    chk("perf_xfer", perf_xfer, m_px);
    chk("perf_stall", perf_stall, m_ps);
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_inputs();
    rst = 1; cfg_start = 0; cfg_valid = 0; flush = 0; pkt_valid = 0;
  endtask

  task automatic push(input logic [IDL-1:0] t);
    pkt_valid = 1; pkt_tag = t; pkt_value = $urandom;
  endtask

  task automatic do_config();
    cfg_start = 1; cycle(); cfg_start = 0;
    for (int i = CHAIN - 1; i >= 0; i--) begin
      cfg_valid = 1; cfg_id = IDL'(i);
      cycle();
    end
    cfg_valid = 0;
    cycle(); cycle();
  endtask

  task automatic rand_phase(input int n, input int pv, input int br, input int fl,
                            input int cs, input int cv, input int rs);
    for (int i = 0; i < n; i++) begin
      rst       = ($urandom_range(999) >= rs);
      pkt_valid = ($urandom_range(99) < pv);
      pkt_tag   = IDL'($urandom);
      pkt_value = $urandom;
      bus_ready = ($urandom_range(99) < br);
      flush     = ($urandom_range(99) < fl);
      cfg_start = ($urandom_range(99) < cs);
      cfg_valid = ($urandom_range(99) < cv);
      cfg_id    = IDL'($urandom);
      cycle();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 0; cfg_start = 0; cfg_valid = 0; flush = 0; pkt_valid = 0; bus_ready = 1;
    cfg_id = '0; pkt_tag = '0; pkt_value = '0;
    @(negedge clk);
    cycle(); cycle();
    idle_inputs();
    cycle();

    // Configuration with two packets pushed while in CONFIG
    cfg_start = 1; cycle(); cfg_start = 0;
    for (int i = CHAIN - 1; i >= 0; i--) begin
      cfg_valid = 1; cfg_id = IDL'(i);
      if (i >= CHAIN - 2) push(IDL'(9 + CHAIN - 1 - i)); else pkt_valid = 0;
      cycle();
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) cycle();

    // Back-to-back tags 1,2,3
    for (int t = 1; t <= 3; t++) begin push(IDL'(t)); cycle(); end
    pkt_valid = 0;
    for (int i = 0; i < 5; i++) cycle();

    // Back-pressure: 5 pushes fill stage + FIFO, 6th refused
    bus_ready = 0;
    for (int t = 4; t < 10; t++) begin push(IDL'(t)); cycle(); end
    pkt_valid = 0; cycle(); cycle();
    bus_ready = 1;
    for (int i = 0; i < 7; i++) cycle();

    // Flush with two queued
    bus_ready = 0;
    push(4'hA); cycle(); push(4'hB); cycle(); pkt_valid = 0;
    flush = 1; cycle(); flush = 0; bus_ready = 1;
    for (int i = 0; i < 6; i++) cycle();

    // Reset mid-stream with packets queued
    do_config();
    bus_ready = 0;
    for (int t = 1; t <= 4; t++) begin push(IDL'(t)); cycle(); end
    pkt_valid = 0;
    rst = 0; cycle(); rst = 1; bus_ready = 1;
    cycle(); cycle();

    // Randomized traffic, configuration, flushes and occasional resets
    for (int r = 0; r < 25; r++) begin
      rand_phase(40, 50, 60, 0, 30, 70, 0);
      rand_phase(60, 60, $urandom_range(20, 100), 4, 5, 50, 5);
      rand_phase(20, 10, 90, 20, 10, 60, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
